uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//   UART transmitter downstream of spi_ctl's TX FIFO. Pops 16-bit words from the
//   FIFO and serialises each one as two 8N1/8E1 frames, low byte first. Frame timing
//   comes from spi_ctl's baud register; enable and parity come from its control
//   register. Returns a 4-bit status word to spi_ctl's STATE register.
// PARAMETERS
//   MIN_DIV    4   smallest clk-cycles-per-bit; lower baud values are clamped up to it
//   STOP_BITS  1   stop bits per frame (1 or 2)
// PORTS
//   clk            in   1   system clock; the block has one clock
//   rst            in   1   reset, synchronous, active-high
//   tx_fifo_data   in   16  FIFO head word, first-word-fall-through, valid when !tx_fifo_empty
//   tx_fifo_empty  in   1   TX FIFO empty
//   tx_fifo_rd     out  1   one-cycle pop strobe
//   baud           in   16  clk cycles per bit (from spi_ctl)
//   control        in   2   [0] tx_enable, [1] even-parity enable (from spi_ctl)
//   state          out  4   [0] busy, [1] fifo empty, [2] high byte active, [3] parity on this frame
//   txd            out  1   serial output, idle high
// BEHAVIOUR
//   Reset values
//   - txd=1, tx_fifo_rd=0, state=4'b0010 (reflects empty), FSM=IDLE, counters=0.
//   - A reset mid-frame drives txd high on the next edge. The partial frame is dropped
//     and is not resent.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE)
//   - IDLE: if control[0] && !tx_fifo_empty, then:
//     - pulse tx_fifo_rd for exactly 1 cycle;
//     - latch tx_fifo_data into word_q, div_q=max(baud,MIN_DIV) and par_q=control[1];
//     - set hi_sel=0 and go to START.
//     txd goes low on the cycle after the pop.
//   - START: txd=0 for div_q cycles.
//   - DATA: 8 bits LSB-first from byte = hi_sel ? word_q[15:8] : word_q[7:0]; each
//     bit is held div_q cycles; 3-bit index.
//   - PARITY (only if par_q): txd = ^byte (even parity), for div_q cycles.
//   - STOP: txd=1 for STOP_BITS*div_q cycles. At the end of STOP:
//     - if hi_sel=0: set hi_sel=1 and go to START (no idle gap between the two bytes);
//     - if hi_sel=1 and control[0] && !empty: pop and start the next word with no gap,
//       same as IDLE entry;
//     - otherwise go to IDLE.
//   Sampling of baud and control
//   - baud and control[1] are sampled only when a word is popped. Changes mid-word
//     take effect on the next word.
//   - Clearing control[0] mid-word does not abort; both bytes complete, then IDLE.
//   Status and counters
//   - busy=1 from the pop cycle until the IDLE return. state is registered, 1-cycle lag.
//   - The bit-period counter is 16-bit and counts down from div_q-1 to 0. Its tick is
//     used only inside the FSM, with no free-running phase, so every frame starts bit-aligned.
//   - Frame length is (10 + par_q + STOP_BITS - 1) * div_q cycles.
//   Boundary conditions
//   - An empty FIFO is never popped.
//   - tx_fifo_rd is never asserted while busy, except on the STOP-end chain cycle.
//   - tx_fifo_empty rising during a word has no effect, because the word is already latched.
// STRUCTURE
//   uart_pkg
//   - typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP} uart_tx_state_t;
//   - localparams CTRL_TX_EN=0, CTRL_PAR_EN=1;
//   - STATE_* bit indices, shared with spi_ctl's STATE decode.
//   uart_bit_timer: sub-module with a load/div input and a tick output (period counter).
//   The FSM, shifter and status logic live in uart_tx_engine.
// TESTING
//   1. baud=16, ctrl=2'b01, one word 16'h4155 -> one tx_fifo_rd pulse. txd goes
//      low 1 cycle later and carries 0x55 bits 1,0,1,0,1,0,1,0, then 0x41. 320 cycles
//      total, no gap between the bytes.
//   2. ctrl=2'b11, baud=8, word 16'h0701 -> byte 0x01 has parity 1, byte 0x07 has
//      parity 1. Each frame is 88 cycles; state[3]=1 during both frames.
//   3. baud=2 with MIN_DIV=4 -> bit period is 4 cycles.
//   4. Three words queued -> 3 pops, each at a STOP-end, and 6 back-to-back frames.
//      busy stays 1 throughout; IDLE is entered once at the end.
//   5. Clear control[0] during the low byte -> the high byte completes, then txd idles
//      high and the next queued word is not popped. Set control[0] again -> the word is popped.
//   6. Assert rst in mid-DATA -> txd=1 and state=4'b0010 next cycle. No pop during
//      reset; after release, IDLE resumes normal operation.
//   7. Change baud mid-word from 16 to 32 -> the current word keeps 16; the next word uses 32.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: FSM states, control
// register bit positions, status word bit positions and the divider clamp.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Bit positions inside spi_ctl's control register.
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_PAR_EN = 1;

  // Bit positions inside the status word returned to spi_ctl's STATE register.
  localparam int STATE_BUSY    = 0;
  localparam int STATE_EMPTY   = 1;
  localparam int STATE_HI_BYTE = 2;
  localparam int STATE_PARITY  = 3;

  // Status word after reset: idle, FIFO reported empty.
  localparam logic [3:0] STATE_RESET = 4'b0010;

  // Bit period actually used: baud values below the minimum are raised to it.
  function automatic logic [15:0] clamp_div(input logic [15:0] baud,
                                            input logic [15:0] min_div);
    return (baud < min_div) ? min_div : baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. A load starts a fresh period, so every frame begins
// bit-aligned; while enabled it ticks on the last cycle of each period and
// reloads itself for the next one.
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] r_count;

  // Count div-1 down to 0, reloading on an explicit load or at the end of a period.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_div - 16'd1;
    end else if (i_en) begin
      if (r_count == '0) begin
        r_count <= i_div - 16'd1;
      end else begin
        r_count <= r_count - 16'd1;
      end
    end
  end

  assign o_tick = i_en && (r_count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter fed by spi_ctl's TX FIFO. Each 16-bit word is sent as two
// frames (low byte first) with optional even parity, back to back, and words
// chain without an idle gap while the FIFO has data and transmit is enabled.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned MIN_DIV   = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tx_fifo_data,
  input  logic        tx_fifo_empty,
  output logic        tx_fifo_rd,
  input  logic [15:0] baud,
  input  logic [1:0]  control,
  output logic [3:0]  state,
  output logic        txd
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_tx_state_t r_fsm;
  logic [15:0]    r_word_q;
  logic [15:0]    r_div_q;
  logic           r_par_q;
  logic           r_hi_sel;
  logic [2:0]     r_bit_idx;
  logic           r_rd;
  logic           r_txd;
  logic [3:0]     r_state;

  logic [7:0]     w_byte;
  logic           w_tick;
  logic           w_stop_end;
  logic           w_pop;
  logic           w_busy;
  logic           w_txd_next;
  logic [15:0]    w_timer_div;

  // Pop decision, current byte and the line level for the current FSM state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_byte      = r_hi_sel ? r_word_q[15:8] : r_word_q[7:0];
    w_busy      = (r_fsm != IDLE);
    w_stop_end  = (r_fsm == STOP) && w_tick && (r_bit_idx == STOP_LAST);
    w_pop       = control[CTRL_TX_EN] && !tx_fifo_empty &&
                  ((r_fsm == IDLE) || (w_stop_end && r_hi_sel));
    w_timer_div = w_pop ? clamp_div(baud, 16'(MIN_DIV)) : r_div_q;
    w_txd_next  = 1'b1;
    case (r_fsm)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_byte[r_bit_idx];
      PARITY:  w_txd_next = ^w_byte;
      default: w_txd_next = 1'b1;
    endcase
  end

  uart_bit_timer u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pop),
    .i_en   (w_busy),
    .i_div  (w_timer_div),
    .o_tick (w_tick)
  );

  // Frame FSM with registered line, pop strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm     <= IDLE;
      r_word_q  <= '0;
      r_div_q   <= '0;
      r_par_q   <= 1'b0;
      r_hi_sel  <= 1'b0;
      r_bit_idx <= '0;
      r_rd      <= 1'b0;
      r_txd     <= 1'b1;
      r_state   <= STATE_RESET;
    end else begin
      r_rd                   <= w_pop;
      r_txd                  <= w_txd_next;
      r_state[STATE_BUSY]    <= w_busy;
      r_state[STATE_EMPTY]   <= tx_fifo_empty;
      r_state[STATE_HI_BYTE] <= r_hi_sel & w_busy;
      r_state[STATE_PARITY]  <= r_par_q & w_busy;

      if (w_pop) begin
        r_word_q  <= tx_fifo_data;
        r_div_q   <= w_timer_div;
        r_par_q   <= control[CTRL_PAR_EN];
        r_hi_sel  <= 1'b0;
        r_bit_idx <= '0;
        r_fsm     <= START;
      end else begin
        case (r_fsm)
          START: begin
            if (w_tick) begin
              r_bit_idx <= '0;
              r_fsm     <= DATA;
            end
          end
          DATA: begin
            if (w_tick) begin
              if (r_bit_idx == 3'd7) begin
                r_bit_idx <= '0;
                r_fsm     <= r_par_q ? PARITY : STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
          PARITY: begin
            if (w_tick) begin
              r_bit_idx <= '0;
              r_fsm     <= STOP;
            end
          end
          STOP: begin
            if (w_tick) begin
              if (r_bit_idx == STOP_LAST) begin
                r_bit_idx <= '0;
                if (!r_hi_sel) begin
                  r_hi_sel <= 1'b1;
                  r_fsm    <= START;
                end else begin
                  r_fsm    <= IDLE;
                end
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
          default: r_fsm <= IDLE;
        endcase
      end
    end
  end

  assign tx_fifo_rd = r_rd;
  assign txd        = r_txd;
  assign state      = r_state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine. A line-level model expands every
// popped word into the expected per-cycle txd/status sequence; a FIFO model
// feeds the DUT and retires words on the DUT's pop strobe.
module tb_uart_tx_engine;

  localparam int MIN_DIV   = 4;
  localparam int STOP_BITS = 1;

  typedef struct packed {
    logic txd;
    logic busy;
    logic hi;
    logic par;
  } line_t;

  localparam line_t IDLE_LINE = '{txd: 1'b1, busy: 1'b0, hi: 1'b0, par: 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tx_fifo_data = '0;
  logic        tx_fifo_empty = 1'b1;
  logic        tx_fifo_rd;
  logic [15:0] baud = 16'd16;
  logic [1:0]  control = 2'b00;
  logic [3:0]  state;
  logic        txd;

  uart_tx_engine #(.MIN_DIV(MIN_DIV), .STOP_BITS(STOP_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_rd    (tx_fifo_rd),
    .baud          (baud),
    .control       (control),
    .state         (state),
    .txd           (txd)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          free_at  = 0;
  int          n_pops   = 0;
  line_t       exp_q[$];
  logic [15:0] fifo_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int eff_div(input logic [15:0] b);
    return (b < 16'(MIN_DIV)) ? MIN_DIV : int'(b);
  endfunction

  task automatic drive_fifo();
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'($urandom);
  endtask

  task automatic fifo_push(input logic [15:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  // Expected line sequence of one word: two frames, low byte first.
  task automatic model_word(input logic [15:0] w, input int div, input bit par);
    logic [7:0] b;
    line_t      e;
    for (int h = 0; h < 2; h++) begin
      b      = (h == 0) ? w[7:0] : w[15:8];
      e.busy = 1'b1;
      e.hi   = (h == 1);
      e.par  = par;
      e.txd  = 1'b0;
      repeat (div) exp_q.push_back(e);
      for (int i = 0; i < 8; i++) begin
        e.txd = b[i];
        repeat (div) exp_q.push_back(e);
      end
      if (par) begin
        e.txd = ^b;
        repeat (div) exp_q.push_back(e);
      end
      e.txd = 1'b1;
      repeat (STOP_BITS * div) exp_q.push_back(e);
    end
  endtask

  // One clock: model decides the coming edge, then DUT outputs are compared.
  task automatic step();
    bit         in_rst;
    bit         pop;
    bit         empty_before;
    int         div;
    line_t      e;
    logic [3:0] exp_state;
    in_rst       = rst;
    empty_before = (fifo_q.size() == 0);
    pop = !in_rst && control[0] && !empty_before && (cyc + 1 >= free_at);
    if (in_rst) begin
      exp_q.delete();
      free_at = 0;
    end else if (pop) begin
      if (exp_q.size() == 0) exp_q.push_back(IDLE_LINE);
      div = eff_div(baud);
      model_word(fifo_q[0], div, control[1]);
      free_at = cyc + 1 + 2 * (10 + int'(control[1]) + STOP_BITS - 1) * div;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (in_rst) begin
      e         = IDLE_LINE;
      exp_state = 4'b0010;
    end else begin
      e         = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_LINE;
      exp_state = {e.par, e.hi, empty_before, e.busy};
    end
    check("txd", 32'(txd), 32'(e.txd));
    check("fifo_rd", 32'(tx_fifo_rd), 32'(pop));
    check("state", 32'(state), 32'(exp_state));
    if (tx_fifo_rd === 1'b1) begin
      n_pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && (fifo_q.size() == 0 || !control[0])) && k < budget) begin
      step();
      k++;
    end
    if (!(exp_q.size() == 0 && (fifo_q.size() == 0 || !control[0])))
      check({tag, "_timeout"}, 32'd0, 32'd1);
    run(3);
  endtask

  initial begin
    int base;
    drive_fifo();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(3);

    // 1: plain 8N1 word at baud 16, two frames back to back.
    base = n_pops;
    baud = 16'd16; control = 2'b01;
    fifo_push(16'h4155);
    wait_idle("t1", 1000);
    check("t1_pops", 32'(n_pops - base), 32'd1);

    // 2: even parity at baud 8.
    base = n_pops;
    baud = 16'd8; control = 2'b11;
    fifo_push(16'h0701);
    wait_idle("t2", 1000);
    check("t2_pops", 32'(n_pops - base), 32'd1);

    // 3: baud below the minimum is clamped.
    base = n_pops;
    baud = 16'd2; control = 2'b01;
    fifo_push(16'(($urandom)));
    wait_idle("t3", 1000);
    check("t3_pops", 32'(n_pops - base), 32'd1);

    // 4: three queued words chain without gaps.
    base = n_pops;
    baud = 16'd5; control = 2'b01;
    fifo_push(16'h1234); fifo_push(16'hA5C3); fifo_push(16'hFF00);
    wait_idle("t4", 2000);
    check("t4_pops", 32'(n_pops - base), 32'd3);

    // 5: disable mid-word, word completes, next word held until re-enabled.
    base = n_pops;
    baud = 16'd4; control = 2'b01;
    fifo_push(16'hBEEF); fifo_push(16'h0F0F);
    run(20);
    control = 2'b00;
    wait_idle("t5a", 1000);
    run(30);
    check("t5_held_pops", 32'(n_pops - base), 32'd1);
    check("t5_fifo_left", 32'(fifo_q.size()), 32'd1);
    control = 2'b01;
    wait_idle("t5b", 1000);
    check("t5_pops", 32'(n_pops - base), 32'd2);

    // 6: reset in mid-DATA drops the partial word; next word follows release.
    base = n_pops;
    baud = 16'd6; control = 2'b01;
    fifo_push(16'h3C5A); fifo_push(16'h6699);
    run(20);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    wait_idle("t6", 1000);
    check("t6_pops", 32'(n_pops - base), 32'd2);

    // 7: baud change mid-word applies to the next word only.
    base = n_pops;
    baud = 16'd16; control = 2'b01;
    fifo_push(16'h8001); fifo_push(16'h7E18);
    run(30);
    baud = 16'd32;
    wait_idle("t7", 2000);
    check("t7_pops", 32'(n_pops - base), 32'd2);

    // Random words, random baud/parity changes while traffic flows.
    control = {1'($urandom), 1'b1};
    baud    = 16'($urandom_range(0, 12));
    for (int i = 0; i < 6; i++) fifo_push(16'($urandom));
    for (int k = 0; k < 1500; k++) begin
      step();
      if ($urandom_range(0, 31) == 0) baud = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 63) == 0) control[1] = ~control[1];
      if ($urandom_range(0, 199) == 0) fifo_push(16'($urandom));
    end
    wait_idle("rand", 6000);
    check("rand_fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
